lvds_rx_word_align: RTL



---
 rtl/lvds_rx_word_align.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lvds_rx_word_align.sv
// lvds_rx_word_align: word-boundary alignment for an 8-bit LVDS deserialiser.
// Pulses the receiver's bitslip input until TRAIN_PATTERN is seen on
// LOCK_COUNT consecutive words. Once locked, it forwards payload words with a
// valid flag.
// Optional build macro LVDS_ALIGN_STATS_EN adds the saturating slip_total and
// relock_total statistics outputs.
module lvds_rx_word_align #(
  parameter logic [7:0]  TRAIN_PATTERN = 8'hB5,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_SLIPS     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       realign,
  output logic       rx_data_align,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       aligned,
  output logic       align_fail
`ifdef LVDS_ALIGN_STATS_EN
  ,
  output logic [7:0] slip_total,
  output logic [7:0] relock_total
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } state_e;

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] SLIP_LIMIT  = 8'(MAX_SLIPS);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] rx_q;
  logic [7:0] match_cnt_q, match_cnt_d;
  logic [7:0] slip_cnt_q, slip_cnt_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;

  logic       rx_data_align_q, rx_data_align_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       aligned_q, aligned_d;
  logic       align_fail_q, align_fail_d;

  // State register, counters and the input word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rx_q         <= '0;
      match_cnt_q  <= '0;
      slip_cnt_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rx_q         <= rx_data;
      match_cnt_q  <= match_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    settle_cnt_d = settle_cnt_q;

    case (state_q)
      ST_IDLE: begin
        match_cnt_d  = '0;
        slip_cnt_d   = '0;
        settle_cnt_d = '0;
        state_d      = ST_CHECK;
      end
      ST_CHECK: begin
        if (rx_q == TRAIN_PATTERN) begin
          match_cnt_d = match_cnt_q + 8'd1;
          if (match_cnt_q == LOCK_LAST) begin
            state_d = ST_LOCKED;
          end
        end else begin
          match_cnt_d = '0;
          if (slip_cnt_q == SLIP_LIMIT) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        slip_cnt_d   = slip_cnt_q + 8'd1;
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        match_cnt_d = '0;
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_LOCKED: state_d = ST_LOCKED;
      ST_FAIL:   state_d = ST_FAIL;
      default:   state_d = ST_IDLE;
    endcase

    // realign overrides every transition. Counter side effects above are
    // harmless because IDLE clears all counters.
    if (realign) begin
      state_d = ST_IDLE;
    end
  end

  // Output decode. Outputs are registered, so each one follows state_q by one
  // clock. realign clears the status outputs on the very next edge. The
  // bitslip pulse is not gated, so a SLIP cycle always finishes its one pulse.
  always_comb begin
    rx_data_align_d = (state_q == ST_SLIP);
    aligned_d       = (state_q == ST_LOCKED) && !realign;
    data_valid_d    = (state_q == ST_LOCKED) && !realign;
    align_fail_d    = (state_q == ST_FAIL) && !realign;
    data_out_d      = data_out_q;
    if ((state_q == ST_LOCKED) && !realign) begin
      data_out_d = rx_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_align_q <= 1'b0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      aligned_q       <= 1'b0;
      align_fail_q    <= 1'b0;
    end else begin
      rx_data_align_q <= rx_data_align_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      aligned_q       <= aligned_d;
      align_fail_q    <= align_fail_d;
    end
  end

  assign rx_data_align = rx_data_align_q;
  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign aligned       = aligned_q;
  assign align_fail    = align_fail_q;

`ifdef LVDS_ALIGN_STATS_EN
  logic [7:0] slip_total_q, slip_total_d;
  logic [7:0] relock_total_q, relock_total_d;

  // Saturating statistics: count issued pulses and LOCKED entries
  always_comb begin
    slip_total_d   = slip_total_q;
    relock_total_d = relock_total_q;
    if (rx_data_align_d && (slip_total_q != 8'hFF)) begin
      slip_total_d = slip_total_q + 8'd1;
    end
    if ((state_d == ST_LOCKED) && (state_q != ST_LOCKED) &&
        (relock_total_q != 8'hFF)) begin
      relock_total_d = relock_total_q + 8'd1;
    end
  end

  // Statistics registers; cleared only by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_total_q   <= '0;
      relock_total_q <= '0;
    end else begin
      slip_total_q   <= slip_total_d;
      relock_total_q <= relock_total_d;
    end
  end

  assign slip_total   = slip_total_q;
  assign relock_total = relock_total_q;
`endif

endmodule
